// File: rtl/axis_bit_packer.sv
`default_nettype none
// ============================================================================
//  Module   : axis_bit_packer
//  Purpose  : Packs AXI-Stream beats carrying a variable number of valid LSBs
//             into dense DATA_W-bit words, LSB-first, with a show-ahead output
//             FIFO, tail flush on tlast and sticky keep-count error flag.
//  Revision : 1.0 - initial release
// ============================================================================
module axis_bit_packer #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = $clog2(DATA_W + 1)
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [DATA_W-1:0]             input_tdata,
  input  logic [CNT_W-1:0]              input_tkeep,
  input  logic                          input_tlast,
  input  logic                          input_tvalid,
  output logic                          input_tready,
  output logic [DATA_W-1:0]             output_tdata,
  output logic [CNT_W-1:0]              output_tkeep,
  output logic                          output_tlast,
  output logic                          output_tvalid,
  input  logic                          output_tready,
  output logic                          err_keep,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int c_addr_w  = $clog2(FIFO_DEPTH);
  localparam int c_entry_w = DATA_W + CNT_W + 1;

  localparam logic [CNT_W-1:0]    c_full_keep = CNT_W'(DATA_W);
  localparam logic [CNT_W:0]      c_full_sum  = (CNT_W + 1)'(DATA_W);
  localparam logic [2*DATA_W-1:0] c_one2      = (2 * DATA_W)'(1);
  localparam logic [c_addr_w:0]   c_depth_lvl = (c_addr_w + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_EMPTY   = 2'd0,
    S_PARTIAL = 2'd1,
    S_FLUSH   = 2'd2
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [DATA_W-1:0]     r_acc, w_acc_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
  logic                  r_rdy_en;
  logic                  r_err;

  logic                  w_keep_over;
  logic [CNT_W-1:0]      w_k;
  logic [2*DATA_W-1:0]   w_mask2;
  logic [2*DATA_W-1:0]   w_ext;
  logic [CNT_W:0]        w_sum;
  logic [CNT_W:0]        w_resid;

  logic                  w_accept;
  logic                  w_wr_en;
  logic [c_entry_w-1:0]  w_wr_entry;
  logic                  w_rd_en;
  logic                  w_full;
  logic                  w_empty;
  logic [c_entry_w-1:0]  w_head;

  logic [c_entry_w-1:0]  r_mem [FIFO_DEPTH];
  logic [c_addr_w-1:0]   r_wr_ptr;
  logic [c_addr_w-1:0]   r_rd_ptr;
  logic [c_addr_w:0]     r_level;

  // Handshake: ready is a pure function of registered state, never of tvalid.
  assign w_full       = (r_level == c_depth_lvl);
  assign w_empty      = (r_level == '0);
  assign input_tready = r_rdy_en && (r_state != S_FLUSH) && !w_full;
  assign w_accept     = input_tvalid && input_tready;
  assign w_rd_en      = !w_empty && output_tready;
  assign err_keep     = r_err;
  assign fifo_level   = r_level;

  // Clamp the keep count, mask the payload and splice it above the current fill,
  // all at double width so the overflow residue is never truncated.
  always_comb begin
    w_keep_over = (input_tkeep > c_full_keep);
    w_k         = w_keep_over ? c_full_keep : input_tkeep;
    w_mask2     = (c_one2 << w_k) - c_one2;
    w_ext       = ((w_mask2 & {{DATA_W{1'b0}}, input_tdata}) << r_cnt)
                | {{DATA_W{1'b0}}, r_acc};
    w_sum       = {1'b0, r_cnt} + {1'b0, w_k};
    w_resid     = w_sum - c_full_sum;
  end

  // Next-state, accumulator update and FIFO write generation.
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_wr_en     = 1'b0;
    w_wr_entry  = '0;
    case (r_state)
      S_FLUSH: begin
        if (!w_full) begin
          w_wr_en     = 1'b1;
          w_wr_entry  = {1'b1, r_cnt, r_acc};
          w_acc_nxt   = '0;
          w_cnt_nxt   = '0;
          w_state_nxt = S_EMPTY;
        end
      end
      default: begin
        if (w_accept) begin
          if (input_tlast) begin
            w_wr_en = 1'b1;
            if (w_sum > c_full_sum) begin
              // Tail spills past one word: emit the full word now, residue in FLUSH.
              w_wr_entry  = {1'b0, c_full_keep, w_ext[DATA_W-1:0]};
              w_acc_nxt   = w_ext[2*DATA_W-1:DATA_W];
              w_cnt_nxt   = w_resid[CNT_W-1:0];
              w_state_nxt = S_FLUSH;
            end else begin
              // Includes the zero-length tail so packet boundaries survive.
              w_wr_entry  = {1'b1, w_sum[CNT_W-1:0], w_ext[DATA_W-1:0]};
              w_acc_nxt   = '0;
              w_cnt_nxt   = '0;
              w_state_nxt = S_EMPTY;
            end
          end else if (w_sum >= c_full_sum) begin
            w_wr_en     = 1'b1;
            w_wr_entry  = {1'b0, c_full_keep, w_ext[DATA_W-1:0]};
            w_acc_nxt   = w_ext[2*DATA_W-1:DATA_W];
            w_cnt_nxt   = w_resid[CNT_W-1:0];
            w_state_nxt = (w_resid != '0) ? S_PARTIAL : S_EMPTY;
          end else begin
            w_acc_nxt   = w_ext[DATA_W-1:0];
            w_cnt_nxt   = w_sum[CNT_W-1:0];
            w_state_nxt = (w_sum != '0) ? S_PARTIAL : S_EMPTY;
          end
        end
      end
    endcase
  end

  // State, accumulator, ready-enable and sticky error registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_EMPTY;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_rdy_en <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_acc    <= w_acc_nxt;
      r_cnt    <= w_cnt_nxt;
      r_rdy_en <= 1'b1;
      if (w_accept && w_keep_over) begin
        r_err <= 1'b1;
      end
    end
  end

  // FIFO storage; contents are only observable through valid pointers.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= w_wr_entry;
    end
  end

  // FIFO pointers and occupancy; simultaneous write and read keep the level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + c_addr_w'(1);
      end
      if (w_rd_en) begin
        r_rd_ptr <= r_rd_ptr + c_addr_w'(1);
      end
      case ({w_wr_en, w_rd_en})
        2'b10:   r_level <= r_level + (c_addr_w + 1)'(1);
        2'b01:   r_level <= r_level - (c_addr_w + 1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Show-ahead head drives the outputs; an empty FIFO presents all zeros.
  always_comb begin
    w_head        = r_mem[r_rd_ptr];
    output_tvalid = !w_empty;
    output_tdata  = '0;
    output_tkeep  = '0;
    output_tlast  = 1'b0;
    if (!w_empty) begin
      output_tdata = w_head[DATA_W-1:0];
      output_tkeep = w_head[DATA_W +: CNT_W];
      output_tlast = w_head[c_entry_w-1];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axis_bit_packer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axis_bit_packer
//  Purpose  : Directed self-checking bench for axis_bit_packer (DATA_W = 16,
//             FIFO_DEPTH = 4) with hand-computed expected words.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axis_bit_packer;

  logic        clk;
  logic        reset_n;
  logic [15:0] input_tdata;
  logic [4:0]  input_tkeep;
  logic        input_tlast;
  logic        input_tvalid;
  logic        input_tready;
  logic [15:0] output_tdata;
  logic [4:0]  output_tkeep;
  logic        output_tlast;
  logic        output_tvalid;
  logic        output_tready;
  logic        err_keep;
  logic [2:0]  fifo_level;

  int n_checks = 0;
  int n_fail   = 0;

  axis_bit_packer #(
    .DATA_W     (16),
    .FIFO_DEPTH (4)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .input_tdata   (input_tdata),
    .input_tkeep   (input_tkeep),
    .input_tlast   (input_tlast),
    .input_tvalid  (input_tvalid),
    .input_tready  (input_tready),
    .output_tdata  (output_tdata),
    .output_tkeep  (output_tkeep),
    .output_tlast  (output_tlast),
    .output_tvalid (output_tvalid),
    .output_tready (output_tready),
    .err_keep      (err_keep),
    .fifo_level    (fifo_level)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Present one beat at a negedge, hold until accepted, return at the next negedge.
  task automatic put(input logic [15:0] d, input logic [4:0] k, input logic l);
    int waited;
    waited       = 0;
    input_tdata  = d;
    input_tkeep  = k;
    input_tlast  = l;
    input_tvalid = 1'b1;
    while (!input_tready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!input_tready) begin
      n_checks++; n_fail++;
      $display("FAIL put_timeout: beat %h never accepted (ready=%b, required 1)", d, input_tready);
    end else begin
      @(posedge clk);
    end
    @(negedge clk);
    input_tvalid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; input_tvalid = 1'b0; input_tdata = '0; input_tkeep = '0;
    input_tlast = 1'b0; output_tready = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (input_tready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b required 0", input_tready); end
    n_checks++; if (output_tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_tvalid: got %b required 0", output_tvalid); end
    n_checks++; if (output_tdata !== 16'h0) begin n_fail++; $display("FAIL rst_tdata: got %h required 0000", output_tdata); end
    n_checks++; if (output_tkeep !== 5'd0 || output_tlast !== 1'b0) begin n_fail++; $display("FAIL rst_keep_last: got %0d/%b required 0/0", output_tkeep, output_tlast); end
    n_checks++; if (err_keep !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b required 0", err_keep); end
    n_checks++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL rst_level: got %0d required 0", fifo_level); end
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++; if (input_tready !== 1'b1) begin n_fail++; $display("FAIL rst_ready_after: got %b required 1", input_tready); end
  endtask

  task automatic test_two_beat();
    put(16'hFFAB, 5'd8, 1'b0);
    n_checks++; if (output_tvalid !== 1'b0) begin n_fail++; $display("FAIL two_beat_early: tvalid got %b required 0", output_tvalid); end
    put(16'h12CD, 5'd8, 1'b1);
    n_checks++;
    if (output_tvalid !== 1'b1 || output_tdata !== 16'hCDAB || output_tkeep !== 5'd16 || output_tlast !== 1'b1) begin
      n_fail++;
      $display("FAIL two_beat_word: got v=%b d=%h k=%0d l=%b required v=1 d=cdab k=16 l=1",
               output_tvalid, output_tdata, output_tkeep, output_tlast);
    end
  endtask

  task automatic test_overflow_flush();
    put(16'h0ABC, 5'd12, 1'b0);
    put(16'h0DEF, 5'd12, 1'b1);
    n_checks++;
    if (output_tvalid !== 1'b1 || output_tdata !== 16'hFABC || output_tkeep !== 5'd16 || output_tlast !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_word1: got v=%b d=%h k=%0d l=%b required v=1 d=fabc k=16 l=0",
               output_tvalid, output_tdata, output_tkeep, output_tlast);
    end
    n_checks++; if (input_tready !== 1'b0) begin n_fail++; $display("FAIL ovf_flush_stall: ready got %b required 0", input_tready); end
    @(negedge clk);
    n_checks++;
    if (output_tvalid !== 1'b1 || output_tdata !== 16'h00DE || output_tkeep !== 5'd8 || output_tlast !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_word2: got v=%b d=%h k=%0d l=%b required v=1 d=00de k=8 l=1",
               output_tvalid, output_tdata, output_tkeep, output_tlast);
    end
    n_checks++; if (input_tready !== 1'b1) begin n_fail++; $display("FAIL ovf_ready_back: got %b required 1", input_tready); end
  endtask

  task automatic test_empty_packet();
    put(16'hFFFF, 5'd0, 1'b1);
    n_checks++;
    if (output_tvalid !== 1'b1 || output_tdata !== 16'h0000 || output_tkeep !== 5'd0 || output_tlast !== 1'b1) begin
      n_fail++;
      $display("FAIL empty_pkt: got v=%b d=%h k=%0d l=%b required v=1 d=0000 k=0 l=1",
               output_tvalid, output_tdata, output_tkeep, output_tlast);
    end
  endtask

  task automatic test_keep_error();
    n_checks++; if (err_keep !== 1'b0) begin n_fail++; $display("FAIL err_before: got %b required 0", err_keep); end
    put(16'h1234, 5'd20, 1'b1);
    n_checks++;
    if (output_tvalid !== 1'b1 || output_tdata !== 16'h1234 || output_tkeep !== 5'd16 || output_tlast !== 1'b1) begin
      n_fail++;
      $display("FAIL err_word: got v=%b d=%h k=%0d l=%b required v=1 d=1234 k=16 l=1",
               output_tvalid, output_tdata, output_tkeep, output_tlast);
    end
    n_checks++; if (err_keep !== 1'b1) begin n_fail++; $display("FAIL err_set: got %b required 1", err_keep); end
    @(negedge clk);
    n_checks++; if (output_tvalid !== 1'b0) begin n_fail++; $display("FAIL err_drained: tvalid got %b required 0", output_tvalid); end
  endtask

  task automatic test_backpressure();
    int sent;
    sent = 0;
    output_tready = 1'b0;
    for (int c = 0; c < 20 && sent < 4; c++) begin
      input_tvalid = 1'b1;
      input_tdata  = 16'hA001 + 16'(sent);
      input_tkeep  = 5'd16;
      input_tlast  = 1'b0;
      if (input_tready) sent++;
      @(negedge clk);
    end
    n_checks++; if (sent != 4) begin n_fail++; $display("FAIL bp_sent: got %0d required 4", sent); end
    n_checks++; if (fifo_level !== 3'd4) begin n_fail++; $display("FAIL bp_level: got %0d required 4", fifo_level); end
    n_checks++; if (input_tready !== 1'b0) begin n_fail++; $display("FAIL bp_ready: got %b required 0", input_tready); end
    @(negedge clk);
    n_checks++;
    if (input_tready !== 1'b0 || fifo_level !== 3'd4 || output_tvalid !== 1'b1 || output_tdata !== 16'hA001) begin
      n_fail++;
      $display("FAIL bp_hold: got rdy=%b lvl=%0d v=%b d=%h required rdy=0 lvl=4 v=1 d=a001",
               input_tready, fifo_level, output_tvalid, output_tdata);
    end
    input_tvalid  = 1'b0;
    output_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (output_tvalid !== 1'b1 || output_tdata !== 16'hA001 + 16'(i) || output_tkeep !== 5'd16 || output_tlast !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_drain%0d: got v=%b d=%h k=%0d l=%b required v=1 d=%h k=16 l=0",
                 i, output_tvalid, output_tdata, output_tkeep, output_tlast, 16'hA001 + 16'(i));
      end
      @(negedge clk);
    end
    n_checks++;
    if (output_tvalid !== 1'b0 || fifo_level !== 3'd0) begin
      n_fail++;
      $display("FAIL bp_empty: got v=%b lvl=%0d required v=0 lvl=0", output_tvalid, fifo_level);
    end
    n_checks++; if (err_keep !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b required 1", err_keep); end
  endtask

  task automatic test_reset_mid_packet();
    put(16'h00AA, 5'd8, 1'b0);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (output_tvalid !== 1'b0 || fifo_level !== 3'd0 || err_keep !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_rst: got v=%b lvl=%0d err=%b required v=0 lvl=0 err=0", output_tvalid, fifo_level, err_keep);
    end
    reset_n = 1'b1;
    @(negedge clk);
    put(16'h5555, 5'd16, 1'b1);
    n_checks++;
    if (output_tvalid !== 1'b1 || output_tdata !== 16'h5555 || output_tkeep !== 5'd16 || output_tlast !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_rst_next: got v=%b d=%h k=%0d l=%b required v=1 d=5555 k=16 l=1",
               output_tvalid, output_tdata, output_tkeep, output_tlast);
    end
  endtask

  initial begin
    test_reset();
    test_two_beat();
    test_overflow_flush();
    test_empty_packet();
    test_keep_error();
    test_backpressure();
    test_reset_mid_packet();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
